// File: rtl/nw_char_pkg.sv
// Shared character-path definitions: 3-bit system codes, ASCII bytes and the
// buffered entry / TX state types used by the alignment-result encoder.
package nw_char_pkg;

  localparam logic [2:0] CODE_GAP = 3'b000;
  localparam logic [2:0] CODE_G   = 3'b001;
  localparam logic [2:0] CODE_INV = 3'b010;
  localparam logic [2:0] CODE_T   = 3'b011;
  localparam logic [2:0] CODE_A   = 3'b100;
  localparam logic [2:0] CODE_C   = 3'b110;

  localparam logic [7:0] ASCII_G   = 8'h47;
  localparam logic [7:0] ASCII_C   = 8'h43;
  localparam logic [7:0] ASCII_A   = 8'h41;
  localparam logic [7:0] ASCII_T   = 8'h54;
  localparam logic [7:0] ASCII_INV = 8'h23;
  localparam logic [7:0] ASCII_GAP = 8'h2D;
  localparam logic [7:0] ASCII_UNK = 8'h3F;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;

  // One buffered input: the code plus its end-of-line marker.
  typedef struct packed {
    logic       last;
    logic [2:0] code;
  } code_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_CR = 2'd1,
    ST_SEND_LF = 2'd2
  } tx_state_t;

endpackage

// File: rtl/cod_out_if.sv
// Bus bundle for cod_out: code input handshake, UART TX write port, status.
// Handshake: a code transfers on a rising edge where char_valid && char_ready;
// a byte is written to the UART TX FIFO on each edge where wr_uart is high.
interface cod_out_if #(
  parameter int N = 8
) ();
  import nw_char_pkg::*;

  logic [2:0]   char_in;
  logic         char_valid;
  logic         char_last;
  logic         char_ready;
  logic         tx_full;
  logic         wr_uart;
  logic [N-1:0] w_data;
  logic         busy;
  tx_state_t    dbg_state;

  modport slave (
    input  char_in,
    input  char_valid,
    input  char_last,
    input  tx_full,
    output char_ready,
    output wr_uart,
    output w_data,
    output busy,
    output dbg_state
  );

  modport master (
    output char_in,
    output char_valid,
    output char_last,
    output tx_full,
    input  char_ready,
    input  wr_uart,
    input  w_data,
    input  busy,
    input  dbg_state
  );

endinterface

// File: rtl/code_fifo.sv
// Small synchronous FIFO holding {last, code} entries ahead of the TX encoder.
// DEPTH must be a power of two (pointers wrap by natural overflow).
module code_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Guard against an upstream that ignores full/empty; state stays consistent.
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cod_out.sv
// Alignment-result encoder: buffers 3-bit system codes, maps them to ASCII and
// writes them to the UART TX FIFO, closing each line with CR LF.
module cod_out
  import nw_char_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  cod_out_if.slave  io
);

  localparam int CW = $clog2(DEPTH) + 1;

  code_entry_t   w_din;
  code_entry_t   w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_ready;
  logic          w_push;
  logic          w_pop;

  tx_state_t     r_state;
  tx_state_t     w_state_nxt;
  logic          r_wr_uart;
  logic          w_wr_nxt;
  logic [N-1:0]  r_w_data;
  logic [N-1:0]  w_data_nxt;

  function automatic logic [7:0] code_to_ascii(input logic [2:0] code);
    case (code)
      CODE_G:   return ASCII_G;
      CODE_C:   return ASCII_C;
      CODE_A:   return ASCII_A;
      CODE_T:   return ASCII_T;
      CODE_INV: return ASCII_INV;
      CODE_GAP: return ASCII_GAP;
      default:  return ASCII_UNK;
    endcase
  endfunction

  assign w_din  = '{last: io.char_last, code: io.char_in};
  assign w_ready = !w_full;
  assign w_push  = io.char_valid && w_ready;

  code_fifo #(
    .WIDTH ($bits(code_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Emit decision uses tx_full of the current cycle; the byte and strobe are
  // registered so the UART FIFO sees them one edge later.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = 1'b0;
    w_data_nxt  = r_w_data;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !io.tx_full) begin
          w_pop      = 1'b1;
          w_wr_nxt   = 1'b1;
          w_data_nxt = N'(code_to_ascii(w_head.code));
          if (w_head.last) begin
            w_state_nxt = ST_SEND_CR;
          end
        end
      end
      ST_SEND_CR: begin
        if (!io.tx_full) begin
          w_wr_nxt    = 1'b1;
          w_data_nxt  = N'(ASCII_CR);
          w_state_nxt = ST_SEND_LF;
        end
      end
      ST_SEND_LF: begin
        if (!io.tx_full) begin
          w_wr_nxt    = 1'b1;
          w_data_nxt  = N'(ASCII_LF);
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_wr_uart <= 1'b0;
      r_w_data  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_uart <= w_wr_nxt;
      r_w_data  <= w_data_nxt;
    end
  end

  assign io.char_ready = w_ready;
  assign io.wr_uart    = r_wr_uart;
  assign io.w_data     = r_w_data;
  assign io.busy       = (w_count != '0) || (r_state != ST_IDLE) || r_wr_uart;
  assign io.dbg_state  = r_state;

endmodule

// File: tb/tb_cod_out.sv
// Directed bench for cod_out: reset behaviour, line encoding, code map,
// backpressure, stall inside the terminator and reset during SEND_CR.
module tb_cod_out;
  import nw_char_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cod_out_if #(.N(8)) bus ();

  cod_out #(.N(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_cyc[$];

  // Strobe capture: edge index of each write plus its byte.
  always @(negedge clk) begin
    if (bus.wr_uart === 1'b1) begin
      obs_q.push_back(bus.w_data);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_code(input logic [2:0] c, input logic l, output int acc_cyc);
    int waitc;
    waitc = 0;
    bus.char_in    = c;
    bus.char_last  = l;
    bus.char_valid = 1'b1;
    while (!bus.char_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 200) check_eq("push_wait", 32'(bus.char_ready), 32'd1);
    @(negedge clk);
    acc_cyc        = cyc;
    bus.char_valid = 1'b0;
    bus.char_last  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic drain_check(input string tag);
    logic [31:0] got;
    wait_idle(tag);
    check_eq({tag, "_nbytes"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hFFFF_FFFF;
      check_eq($sformatf("%s_b%0d", tag, i), got, 32'(exp_q[i]));
    end
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int dummy;
    bus.char_in    = 3'b000;
    bus.char_valid = 1'b0;
    bus.char_last  = 1'b0;
    bus.tx_full    = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_wr_uart", 32'(bus.wr_uart), 32'd0);
    check_eq("rst_w_data", 32'(bus.w_data), 32'd0);
    check_eq("rst_ready", 32'(bus.char_ready), 32'd1);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-stream with codes buffered
    bus.tx_full = 1'b1;
    send_code(CODE_G, 1'b0, dummy);
    send_code(CODE_A, 1'b1, dummy);
    check_eq("mid_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", 32'(bus.char_ready), 32'd1);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_rst_wr", 32'(bus.wr_uart), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.tx_full = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("mid_no_strobe", 32'(obs_q.size()), 32'd0);
    check_eq("mid_busy_after", 32'(bus.busy), 32'd0);

    // Line "GATC"
    send_code(CODE_G, 1'b0, acc0);
    send_code(CODE_A, 1'b0, dummy);
    send_code(CODE_T, 1'b0, dummy);
    send_code(CODE_C, 1'b1, dummy);
    wait_idle("gatc_pre");
    if (obs_cyc.size() >= 6) begin
      check_eq("gatc_latency", 32'(obs_cyc[0]), 32'(acc0 + 1));
      check_eq("gatc_consec", 32'(obs_cyc[5] - obs_cyc[0]), 32'd5);
    end
    exp_q = '{8'h47, 8'h41, 8'h54, 8'h43, 8'h0D, 8'h0A};
    drain_check("gatc");

    // All eight codes, last on the final one
    for (int c = 0; c < 8; c++) send_code(3'(c), (c == 7), dummy);
    wait_idle("map_pre");
    if (obs_cyc.size() >= 10) check_eq("map_rate", 32'(obs_cyc[9] - obs_cyc[0]), 32'd9);
    exp_q = '{8'h2D, 8'h47, 8'h23, 8'h54, 8'h41, 8'h3F, 8'h43, 8'h3F, 8'h0D, 8'h0A};
    drain_check("map");

    // Backpressure: buffer fills, fifth code waits
    bus.tx_full = 1'b1;
    send_code(CODE_A, 1'b0, dummy);
    send_code(CODE_C, 1'b0, dummy);
    send_code(CODE_G, 1'b0, dummy);
    send_code(CODE_T, 1'b0, dummy);
    bus.char_in    = CODE_GAP;
    bus.char_last  = 1'b1;
    bus.char_valid = 1'b1;
    check_eq("bp_ready_low", 32'(bus.char_ready), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("bp_ready_held", 32'(bus.char_ready), 32'd0);
    check_eq("bp_no_strobe", 32'(obs_q.size()), 32'd0);
    check_eq("bp_busy", 32'(bus.busy), 32'd1);
    bus.tx_full = 1'b0;
    send_code(CODE_GAP, 1'b1, dummy);
    exp_q = '{8'h41, 8'h43, 8'h47, 8'h54, 8'h2D, 8'h0D, 8'h0A};
    drain_check("bp");
    check_eq("bp_ready_back", 32'(bus.char_ready), 32'd1);

    // Stall right after the CR strobe
    fork
      begin
        int n;
        n = 0;
        while (!(bus.wr_uart && bus.w_data == 8'h0D) && n < 100) begin
          @(negedge clk);
          n++;
        end
        bus.tx_full = 1'b1;
        @(negedge clk);
        check_eq("stall_state", 32'(bus.dbg_state), 32'(ST_SEND_LF));
        check_eq("stall_no_wr", 32'(bus.wr_uart), 32'd0);
        repeat (2) @(negedge clk);
        bus.tx_full = 1'b0;
      end
      begin
        send_code(CODE_T, 1'b1, dummy);
        send_code(CODE_C, 1'b0, dummy);
        send_code(CODE_G, 1'b1, dummy);
      end
    join
    wait_idle("stall_pre");
    if (obs_cyc.size() >= 4) begin
      check_eq("stall_lf_gap", 32'(obs_cyc[2] - obs_cyc[1]), 32'd4);
      check_eq("stall_next_line", 32'(obs_cyc[3] - obs_cyc[2]), 32'd1);
    end
    exp_q = '{8'h54, 8'h0D, 8'h0A, 8'h43, 8'h47, 8'h0D, 8'h0A};
    drain_check("stall");

    // Reset while in SEND_CR with two codes still buffered
    bus.tx_full = 1'b1;
    send_code(CODE_A, 1'b1, dummy);
    send_code(CODE_G, 1'b0, dummy);
    send_code(CODE_C, 1'b0, dummy);
    bus.tx_full = 1'b0;
    @(negedge clk);
    bus.tx_full = 1'b1;
    check_eq("rcr_state", 32'(bus.dbg_state), 32'(ST_SEND_CR));
    check_eq("rcr_wr", 32'(bus.wr_uart), 32'd1);
    check_eq("rcr_data", 32'(bus.w_data), 32'h41);
    rst_n = 1'b0;
    #1;
    check_eq("rcr_rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.tx_full = 1'b0;
    repeat (10) @(negedge clk);
    exp_q = '{8'h41};
    drain_check("rcr");
    check_eq("rcr_ready", 32'(bus.char_ready), 32'd1);
    check_eq("rcr_end_state", 32'(bus.dbg_state), 32'(ST_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cod_out.md
# cod_out

Encoder for the alignment-result path: the inverse of the UART-RX character converter. Accepts a stream of 3-bit system codes (G/C/A/T/invalid/gap) from the alignment core and buffers them in a small FIFO. Translates each code to ASCII and writes it into the UART TX FIFO, respecting its `full` flag. On the last character of a line it appends CR LF, so each aligned sequence appears as one terminal line.

## Interface
- `N`, 8: UART data width (byte).
- `DEPTH`, 4: input code buffer depth, power of two, at least 2.
- `clk`  in  1: system clock; all state on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `char_in`  in  3: system code to transmit.
- `char_valid`  in  1: `char_in`/`char_last` valid this cycle.
- `char_last`  in  1: the code is the final one of a line; append CR LF after it.
- `char_ready`  out  1: buffer can accept; a transfer occurs when `char_valid && char_ready`.
- `tx_full`  in  1: UART TX FIFO full.
- `wr_uart`  out  1: one-cycle write strobe to UART TX FIFO.
- `w_data`  out  N: byte to write, valid while `wr_uart`=1.
- `busy`  out  1: buffer non-empty or terminator pending.

## Operation
- Code map: 001→0x47 'G'; 110→0x43 'C'; 100→0x41 'A'; 011→0x54 'T'; 010→0x23 '#'; 000→0x2D '-' (gap); 101, 111→0x3F '?'.
- Input buffer: DEPTH entries of {last, code}.
  - `char_ready` = (count < DEPTH), with no bypass.
  - A push while full is impossible by the handshake.
  - A simultaneous push and pop leaves the count unchanged.
- FSM states: IDLE, SEND_CR, SEND_LF.
  - IDLE: if buffer non-empty and `tx_full`=0, pop the head, register `wr_uart`=1 and `w_data`=map(code). If the popped entry's `last`=1, go to SEND_CR; otherwise stay in IDLE. Back-to-back pops are allowed, so one byte per cycle is possible.
  - SEND_CR: if `tx_full`=0, emit 0x0D and go to SEND_LF; otherwise hold.
  - SEND_LF: if `tx_full`=0, emit 0x0A and go to IDLE; otherwise hold.
  - No pop occurs while in SEND_CR or SEND_LF; input may continue filling the buffer.
- `tx_full` is sampled in the same cycle as the emit decision. No byte is emitted in a cycle where `tx_full`=1 at the edge.
- `busy` = (count≠0) || (state≠IDLE) || `wr_uart`.
- Reset values:
  - `wr_uart`=0, `w_data`=0, `char_ready`=1, `busy`=0.
  - State IDLE, buffer empty, pointers 0.
- Reset mid-line discards buffered codes and any pending CR/LF. No partial terminator is sent after release.

## Timing
- `wr_uart` and `w_data` are registered.
- Latency: code accepted at edge k, with buffer empty and `tx_full`=0, produces `wr_uart`=1 in the cycle following edge k+1 (2 cycles).
- For a `last` code emitted after edge j, CR follows after edge j+1 and LF after edge j+2, given `tx_full`=0.
- Throughput: 1 byte/cycle sustained. A line of L codes occupies L+2 strobes.
- `tx_full` stall: each held cycle delays output by exactly one cycle; no byte is lost or duplicated.
- `char_ready` reflects the registered count. It deasserts the cycle after the DEPTH-th entry is stored, unless a pop occurs in the same cycle.
- Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.

## Structure
- Shared package/header `nw_char_pkg`:
  - 3-bit code constants (CODE_G, CODE_C, CODE_A, CODE_T, CODE_INV, CODE_GAP).
  - ASCII constants (0x47, 0x43, 0x41, 0x54, 0x23, 0x2D, 0x3F, 0x0D, 0x0A).
  - Also to be used by the RX converter.
- Sub-module `code_fifo`: sync FIFO, parameters WIDTH=4 and DEPTH; ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`.
- The top level holds the FSM and the map function.

## Test plan
- Reset then idle: `rst_n`=0 mid-stream → all outputs at reset values, `char_ready`=1, no `wr_uart` for 10 cycles after release.
- Line "GATC": push 001, 100, 011, 110(last), `tx_full`=0 → `wr_uart` strobes 0x47, 0x41, 0x54, 0x43, 0x0D, 0x0A on 6 consecutive cycles, first one 2 cycles after the first accept.
- Map coverage: push all 8 codes, last on the final one → 0x2D, 0x47, 0x23, 0x54, 0x41, 0x3F, 0x43, 0x3F, 0x0D, 0x0A.
- Backpressure: hold `tx_full`=1 while pushing 5 codes → `char_ready` drops after 4 accepts, no strobes. Release `tx_full` → bytes emitted in order, `char_ready` returns.
- Stall inside terminator: `tx_full`=1 for 3 cycles right after the CR strobe → LF emitted exactly once when `tx_full` falls; the next line's first byte follows LF.
- Reset during SEND_CR with 2 codes buffered → no CR/LF and no buffered bytes after release; buffer empty, `busy`=0.
